// File: rtl/sequential_restoring_divider.sv
// rtl/sequential_restoring_divider.sv - multi-cycle unsigned restoring divider
//
// Purpose: divides a DW-bit dividend by a VW-bit divisor, one quotient bit
// per clock. The request is accepted with start, and results are returned
// with a one-cycle done pulse. Back-to-back requests are supported by
// accepting start in the DONE cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request, sampled only while busy=0 (IDLE or DONE)
//   in1    DW-bit unsigned dividend, sampled with start
//   in2    VW-bit unsigned divisor, sampled with start
//   quot   DW-bit quotient, held until the next completion
//   rem    VW-bit remainder, held like quot
//   busy   high while a division is iterating
//   done   one-cycle pulse: quot/rem/dz are valid
//   dz     divide-by-zero flag, held like quot
module sequential_restoring_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] in1,
  input  logic [VW-1:0] in2,
  output logic [DW-1:0] quot,
  output logic [VW-1:0] rem,
  output logic          busy,
  output logic          done,
  output logic          dz
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // q_sh starts as the dividend; each step shifts its MSB into the partial
  // remainder and shifts the new quotient bit in at the LSB, so after DW
  // steps it holds the quotient.
  logic [DW-1:0] q_sh;
  logic [VW:0]   r_part;
  logic [VW-1:0] dvs;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          last_step;
  logic [VW+1:0] trial;
  logic          ge;
  logic [VW:0]   r_new;
  logic [DW-1:0] q_new;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_step = (cnt == CW'(DW - 1));

  // One restoring step. The subtraction is one bit wider than the shifted
  // partial remainder so its MSB is the borrow (negative trial).
  always_comb begin
    trial = {r_part, q_sh[DW-1]} - {2'b00, dvs};
    ge    = ~trial[VW+1];
    r_new = ge ? trial[VW:0] : {r_part[VW-1:0], q_sh[DW-1]};
    q_new = {q_sh[DW-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (in2 != '0) ? RUN : DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_sh   <= '0;
      r_part <= '0;
      dvs    <= '0;
      cnt    <= '0;
      quot   <= '0;
      rem    <= '0;
      dz     <= 1'b0;
    end else if (accept) begin
      q_sh   <= in1;
      r_part <= '0;
      dvs    <= in2;
      cnt    <= '0;
      // Divide-by-zero skips the iteration and publishes the saturated
      // result directly; the normal path leaves outputs untouched until
      // the final step.
      if (in2 == '0) begin
        quot <= '1;
        rem  <= '0;
        dz   <= 1'b1;
      end
    end else if (state == RUN) begin
      q_sh   <= q_new;
      r_part <= r_new;
      cnt    <= cnt + CW'(1);
      if (last_step) begin
        quot <= q_new;
        rem  <= r_new[VW-1:0];
        dz   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sequential_restoring_divider.sv
// tb/tb_sequential_restoring_divider.sv - scoreboard bench for sequential_restoring_divider
module tb_sequential_restoring_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in1;
  logic [7:0]  in2;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        busy;
  logic        done;
  logic        dz;

  sequential_restoring_divider #(.DW(16), .VW(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .quot  (quot),
    .rem   (rem),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("quot", 32'(quot), 32'(e.q));
        chk("rem", 32'(rem), 32'(e.r));
        chk("dz", 32'(dz), 32'(e.dz));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Reference: plain unsigned division; divisor 0 saturates the quotient.
  task automatic do_div(input logic [15:0] a, input logic [7:0] b);
    exp_t x;
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk("accept_timeout", 32'(busy), 32'd0);
      return;
    end
    start = 1'b1;
    in1   = a;
    in2   = b;
    if (b == 0) begin
      x.q = 16'hFFFF; x.r = 8'd0; x.dz = 1'b1; x.lat = 0;
    end else begin
      x.q = a / b; x.r = a % b; x.dz = 1'b0; x.lat = 16;
    end
    x.acc = cyc + 1;
    sb.push_back(x);
    @(posedge clk);
    #1;
    start = 1'b0;
    in1   = 16'($urandom);
    in2   = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy || done) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  b;
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_quot", 32'(quot), 32'd0);
    chk("reset_rem", 32'(rem), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_dz", 32'(dz), 32'd0);
    rst = 1'b0;

    do_div(16'd1419, 8'd43);
    do_div(16'd1000, 8'd7);
    do_div(16'd65535, 8'd255);
    do_div(16'd65535, 8'd1);
    do_div(16'd0, 8'd5);
    do_div(16'd254, 8'd255);
    do_div(16'd255, 8'd255);
    do_div(16'd65535, 8'd2);
    wait_idle();

    // Divide-by-zero, then held outputs, then cleared by the next division.
    do_div(16'd500, 8'd0);
    wait_idle();
    chk("dz_held", 32'(dz), 32'd1);
    chk("quot_held", 32'(quot), 32'hFFFF);
    chk("done_low_after_pulse", 32'(done), 32'd0);
    do_div(16'd20, 8'd6);
    wait_idle();

    // Start re-pulsed while busy is ignored; start on the done cycle chains.
    do_div(16'd1000, 8'd7);
    repeat (3) @(negedge clk);
    start = 1'b1; in1 = 16'd9; in2 = 8'd3;
    @(negedge clk);
    start = 1'b0;
    do_div(16'd9, 8'd3);
    wait_idle();

    // Reset mid-run discards the division and never pulses done.
    do_div(16'd1419, 8'd43);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_busy", 32'(busy), 32'd0);
    chk("midrun_done", 32'(done), 32'd0);
    chk("midrun_quot", 32'(quot), 32'd0);
    chk("midrun_rem", 32'(rem), 32'd0);
    chk("midrun_dz", 32'(dz), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    do_div(16'd1419, 8'd43);
    wait_idle();

    // Random sweep; every fourth dividend is an exact product so the
    // quotient must recover the multiplicand.
    for (int i = 0; i < 2000; i++) begin
      b = 8'($urandom_range(1, 255));
      if (i % 4 == 0) a = 16'($urandom_range(0, 255) * b);
      else            a = 16'($urandom_range(0, 65535));
      do_div(a, b);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
